// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the multi-port register file.
//   DEF_N / DEF_R            default register width and address width
//   DEF_SP_IDX / DEF_SP_INIT stack-pointer index and its reset value
//   DEF_LINK_IDX             link register written by jal
//   MAX_N / MAX_R            widest data/address a write request can carry
//   wr_req_t                 one write request {we, addr, data}
package regfile_pkg;

    localparam int          DEF_N        = 32;
    localparam int          DEF_R        = 5;
    localparam int          DEF_SP_IDX   = 29;
    localparam logic [31:0] DEF_SP_INIT  = 32'h000000FF;
    localparam int          DEF_LINK_IDX = 31;

    // Write requests are sized for the widest supported configuration so
    // the same struct serves every parameterisation (N <= 64, R <= 8).
    localparam int MAX_N = 64;
    localparam int MAX_R = 8;

    typedef struct packed {
        logic             we;
        logic [MAX_R-1:0] addr;
        logic [MAX_N-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Tracks which registers have an outstanding producer and reports, per read
// port, whether the addressed register is still pending.
//   clk, reset_n       clock and asynchronous active-low reset
//   iss_valid/iss_addr marks a destination register pending at the next edge
//   clr                one bit per register that receives a write this cycle
//   ra                 flattened read addresses, port i at [i*R +: R]
//   rs_busy            pending flag for each read port
module regfile_scoreboard #(
    parameter int R      = 5,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               iss_valid,
    input  logic [R-1:0]       iss_addr,
    input  logic [2**R-1:0]    clr,
    input  logic [NREAD*R-1:0] ra,
    output logic [NREAD-1:0]   rs_busy
);

    localparam int              DEPTH = 2**R;
    localparam logic [DEPTH-1:0] BIT0 = DEPTH'(1);
    localparam bit              BYP   = (BYPASS != 0);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] set_vec;
    logic [R-1:0]     rd_addr [NREAD];

    assign set_vec = iss_valid ? (BIT0 << iss_addr) : '0;

    // Clear first, then set, so a new producer issued in the same cycle as
    // the old one's writeback keeps the register pending. Bit 0 never sets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr) | set_vec) & ~BIT0;
        end
    end

    // A writeback landing this cycle already satisfies the reader when
    // forwarding is on, unless a fresh producer claims the same register.
    always_comb begin
        rs_busy = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_addr[i] = ra[i*R +: R];
            rs_busy[i] = pending[rd_addr[i]];
            if (BYP && clr[rd_addr[i]] && !(iss_valid && (iss_addr == rd_addr[i]))) begin
                rs_busy[i] = 1'b0;
            end
            if (rd_addr[i] == '0) begin
                rs_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file with two writeback ports, a link write, optional
// write-to-read forwarding and a pending-register scoreboard.
//   clk, reset_n          clock and asynchronous active-low reset
//   we_a, wa_a, wd_a      primary write port (ALU writeback), highest priority
//   we_b, wa_b, wd_b      secondary write port (load writeback)
//   jal, pcplus4          link write of pcplus4 to LINK_IDX, lowest priority
//   ra / rd               flattened read addresses / data, port i at slice i
//   iss_valid, iss_addr   marks a destination register pending
//   rs_busy               pending flag per read port
//   wr_conflict           both write ports hit the same nonzero register
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int         N        = DEF_N,
    parameter int         R        = DEF_R,
    parameter int         NREAD    = 2,
    parameter int         BYPASS   = 1,
    parameter int         SP_IDX   = DEF_SP_IDX,
    parameter logic [N-1:0] SP_INIT = N'(DEF_SP_INIT),
    parameter int         LINK_IDX = DEF_LINK_IDX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we_a,
    input  logic [R-1:0]       wa_a,
    input  logic [N-1:0]       wd_a,
    input  logic               we_b,
    input  logic [R-1:0]       wa_b,
    input  logic [N-1:0]       wd_b,
    input  logic               jal,
    input  logic [N-1:0]       pcplus4,
    input  logic [NREAD*R-1:0] ra,
    output logic [NREAD*N-1:0] rd,
    input  logic               iss_valid,
    input  logic [R-1:0]       iss_addr,
    output logic [NREAD-1:0]   rs_busy,
    output logic               wr_conflict
);

    localparam int DEPTH = 2**R;
    localparam bit BYP   = (BYPASS != 0);

    logic [N-1:0]     rf      [DEPTH];
    wr_req_t          req     [3];
    logic [DEPTH-1:0] wr_hit;
    logic [N-1:0]     wr_data [DEPTH];
    logic [R-1:0]     rd_addr [NREAD];

    // Index 0 is port A, 1 is port B, 2 is the link write.
    always_comb begin
        req[0] = '{we: we_a, addr: MAX_R'(wa_a), data: MAX_N'(wd_a)};
        req[1] = '{we: we_b, addr: MAX_R'(wa_b), data: MAX_N'(wd_b)};
        req[2] = '{we: jal,  addr: MAX_R'(LINK_IDX), data: MAX_N'(pcplus4)};
    end

    // Resolve one winner per register. Sources are scanned from lowest to
    // highest priority so port A overrides B, which overrides jal. Register 0
    // is never marked hit, which discards writes to it.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            wr_hit[k]  = 1'b0;
            wr_data[k] = '0;
        end
        for (int k = 1; k < DEPTH; k++) begin
            for (int s = 2; s >= 0; s--) begin
                if (req[s].we && (req[s].addr == MAX_R'(k))) begin
                    wr_hit[k]  = 1'b1;
                    wr_data[k] = N'(req[s].data);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                rf[k] <= (k == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (wr_hit[k]) begin
                    rf[k] <= wr_data[k];
                end
            end
        end
    end

    // Register 0 is forced to zero on read regardless of storage contents.
    always_comb begin
        rd = '0;
        for (int i = 0; i < NREAD; i++) begin
            rd_addr[i] = ra[i*R +: R];
            if (rd_addr[i] == '0) begin
                rd[i*N +: N] = '0;
            end else if (BYP && wr_hit[rd_addr[i]]) begin
                rd[i*N +: N] = wr_data[rd_addr[i]];
            end else begin
                rd[i*N +: N] = rf[rd_addr[i]];
            end
        end
    end

    assign wr_conflict = we_a & we_b & (wa_a == wa_b) & (wa_a != '0);

    // The per-register write winners double as the scoreboard's clear vector.
    regfile_scoreboard #(
        .R      (R),
        .NREAD  (NREAD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .clr       (wr_hit),
        .ra        (ra),
        .rs_busy   (rs_busy)
    );

endmodule
